// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 scanned key matrix with per-key debounce and an event FIFO.
// One row is driven low per dwell period; columns are synchronized and sampled on
// the last dwell cycle. Committed key changes are queued for CPU readout.
// Optional feature macro: KEYPAD_RELEASE_EVT_EN (also queue release events).
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          o_clk,
  input  logic                          rst,
  output logic [3:0]                    row_n,
  input  logic [3:0]                    col_n,
  output logic                          key_valid,
  output logic [7:0]                    key_code,
  input  logic                          key_pop,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic [15:0]                   pressed
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       DB_MAX   = 4'(DEBOUNCE_SCANS);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_INC  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_INC  = PTR_W'(1);

`ifdef KEYPAD_RELEASE_EVT_EN
  localparam logic REL_EVT = 1'b1;
`else
  localparam logic REL_EVT = 1'b0;
`endif

  // Scan and sampling state
  logic [3:0]       col_meta_r;
  logic [3:0]       col_sync_r;
  logic [CNT_W-1:0] dwell_cnt_r;
  logic [1:0]       row_r;
  logic [3:0]       row_n_r;
  logic             sample_s;
  logic [3:0]       key_down_s;
  logic [1:0]       row_nxt_s;

  // Debounce state
  logic [3:0]       db_r [16];
  logic [3:0]       db_nxt_s [16];
  logic [15:0]      pressed_r;
  logic [15:0]      pressed_nxt_s;
  logic [3:0]       pend_s;
  logic [1:0]       sel_s;
  logic             commit_s;
  logic             push_nxt_s;
  logic [7:0]       code_nxt_s;
  logic             push_r;
  logic [7:0]       push_code_r;

  // FIFO state
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [PTR_W:0]   count_r;
  logic [PTR_W:0]   count_nxt_s;
  logic             pop_s;
  logic             full_s;
  logic             wr_en_s;
  logic             drop_s;
  logic [7:0]       head_nxt_s;
  logic             key_valid_r;
  logic [7:0]       key_code_r;
  logic             overflow_r;

  assign sample_s   = (dwell_cnt_r == CNT_LAST);
  assign key_down_s = ~col_sync_r;
  assign row_nxt_s  = row_r + 2'd1;

  // Two-flop synchronizer for the asynchronous column inputs; idle level is high.
  always_ff @(posedge o_clk or negedge rst) begin
    if (!rst) begin
      col_meta_r <= 4'hF;
      col_sync_r <= 4'hF;
    end else begin
      col_meta_r <= col_n;
      col_sync_r <= col_meta_r;
    end
  end

  // Dwell counter and row sequencing; the row advances on the sample cycle.
  always_ff @(posedge o_clk or negedge rst) begin
    if (!rst) begin
      dwell_cnt_r <= '0;
      row_r       <= 2'd0;
      row_n_r     <= 4'b1110;
    end else if (sample_s) begin
      dwell_cnt_r <= '0;
      row_r       <= row_nxt_s;
      row_n_r     <= ~(4'b0001 << row_nxt_s);
    end else begin
      dwell_cnt_r <= dwell_cnt_r + CNT_ONE;
    end
  end

  // Per-key debounce update for the sampled row and lowest-column commit selection.
  always_comb begin
    db_nxt_s      = db_r;
    pressed_nxt_s = pressed_r;
    pend_s        = 4'b0000;
    sel_s         = 2'd0;
    commit_s      = 1'b0;
    push_nxt_s    = 1'b0;
    code_nxt_s    = 8'h00;
    if (sample_s) begin
      for (int c = 0; c < 4; c++) begin
        if (key_down_s[c] != pressed_r[{row_r, 2'(c)}]) begin
          if (db_r[{row_r, 2'(c)}] != DB_MAX) begin
            db_nxt_s[{row_r, 2'(c)}] = db_r[{row_r, 2'(c)}] + 4'd1;
          end else begin
            db_nxt_s[{row_r, 2'(c)}] = db_r[{row_r, 2'(c)}];
          end
        end else begin
          db_nxt_s[{row_r, 2'(c)}] = 4'd0;
        end
        pend_s[c] = (db_nxt_s[{row_r, 2'(c)}] == DB_MAX);
      end
      if (pend_s[0]) begin
        commit_s = 1'b1;
        sel_s    = 2'd0;
      end else if (pend_s[1]) begin
        commit_s = 1'b1;
        sel_s    = 2'd1;
      end else if (pend_s[2]) begin
        commit_s = 1'b1;
        sel_s    = 2'd2;
      end else if (pend_s[3]) begin
        commit_s = 1'b1;
        sel_s    = 2'd3;
      end else begin
        commit_s = 1'b0;
      end
      if (commit_s) begin
        pressed_nxt_s[{row_r, sel_s}] = ~pressed_r[{row_r, sel_s}];
        db_nxt_s[{row_r, sel_s}]      = 4'd0;
        push_nxt_s = ~pressed_r[{row_r, sel_s}] | REL_EVT;
        code_nxt_s = {~pressed_r[{row_r, sel_s}], 3'b000, row_r, sel_s};
      end else begin
        push_nxt_s = 1'b0;
      end
    end else begin
      commit_s = 1'b0;
    end
  end

  // Debounce counters, key map and the one-cycle event staging register.
  always_ff @(posedge o_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) db_r[i] <= 4'd0;
      pressed_r   <= 16'h0000;
      push_r      <= 1'b0;
      push_code_r <= 8'h00;
    end else begin
      db_r        <= db_nxt_s;
      pressed_r   <= pressed_nxt_s;
      push_r      <= push_nxt_s;
      push_code_r <= code_nxt_s;
    end
  end

  assign pop_s   = key_pop && (count_r != '0);
  assign full_s  = (count_r == FULL_CNT);
  assign wr_en_s = push_r && (!full_s || pop_s);
  assign drop_s  = push_r && full_s && !pop_s;

  // FIFO next count/pointer and the next show-ahead head value.
  always_comb begin
    count_nxt_s  = count_r;
    rd_ptr_nxt_s = rd_ptr_r;
    head_nxt_s   = 8'h00;
    case ({wr_en_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_INC;
      2'b01:   count_nxt_s = count_r - CNT_INC;
      default: count_nxt_s = count_r;
    endcase
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_INC;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    // The entry being written this cycle bypasses storage when it becomes head.
    if (count_nxt_s == '0) begin
      head_nxt_s = 8'h00;
    end else if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = push_code_r;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // FIFO storage array.
  always_ff @(posedge o_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'h00;
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_code_r;
    end else begin
      mem_r <= mem_r;
    end
  end

  // FIFO pointers, count, registered head/valid and the sticky overflow flag.
  always_ff @(posedge o_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      key_valid_r <= 1'b0;
      key_code_r  <= 8'h00;
      overflow_r  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_INC;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      key_valid_r <= (count_nxt_s != '0);
      key_code_r  <= head_nxt_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign row_n      = row_n_r;
  assign key_valid  = key_valid_r;
  assign key_code   = key_code_r;
  assign fifo_count = count_r;
  assign overflow   = overflow_r;
  assign pressed    = pressed_r;

endmodule
